mmc3_scanline_irq: RTL and testbench

- MMC3-style scanline IRQ generator that drives the cartridge `irq` output of the multicart top level.
- Filters PPU A12 rising edges, clocks an 8-bit down-counter, and raises an active-low IRQ when the counter reaches zero while enabled.
- Used by the MMC3 family (#004, #118, #189 and similar mappers); mapper decode supplies the register write strobes.

---
 rtl/mmc3_scanline_irq.sv | 127 ++++++++++++
 tb/tb_mmc3_scanline_irq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mmc3_scanline_irq.sv
// MMC3-style scanline IRQ: filtered PPU A12 edge detector clocking an 8-bit reload/down counter.
// Optional `define MMC3_IRQ_REV_A_EN selects the rev A (Sharp) zero-fire rule; default is rev B.
module mmc3_scanline_irq #(
    parameter int A12_LOW_MIN = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       m2,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       reg_we,
    input  logic [1:0] reg_sel,
    input  logic [7:0] reg_data,
    input  logic       ppu_a12,
    output logic       irq,
    output logic [7:0] counter_dbg
);

    localparam logic [2:0] LOW_MIN = 3'(A12_LOW_MIN);

    logic [SYNC_STAGES-1:0] a12_sync;
    logic                   a12_s;
    logic [2:0]             low_cnt;
    logic                   tick;

    logic [7:0] latch, latch_nxt;
    logic [7:0] counter, counter_nxt;
    logic       reload_flag, reload_nxt;
    logic       irq_en, irq_en_nxt;
    logic       pending, pending_nxt;

    logic       wr_latch, wr_reload, wr_ack, wr_en;
    logic       tick_en;
    logic       reload_req;
    logic       fire_ok;

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            a12_sync <= '0;
        end else begin
            a12_sync <= {a12_sync[SYNC_STAGES-2:0], ppu_a12};
        end
    end

    assign a12_s = a12_sync[SYNC_STAGES-1];

    // low_cnt counts consecutive low samples, so a nonzero value also implies a12_s was low last cycle.
    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt <= 3'd0;
        end else if (a12_s) begin
            low_cnt <= 3'd0;
        end else if (low_cnt != 3'd7) begin
            low_cnt <= low_cnt + 3'd1;
        end
    end

    assign tick = a12_s && (low_cnt >= LOW_MIN);

    assign wr_latch  = enable && reg_we && (reg_sel == 2'd0);
    assign wr_reload = enable && reg_we && (reg_sel == 2'd1);
    assign wr_ack    = enable && reg_we && (reg_sel == 2'd2);
    assign wr_en     = enable && reg_we && (reg_sel == 2'd3);
    assign tick_en   = enable && tick;

    assign reload_req = reload_flag || wr_reload;

`ifdef MMC3_IRQ_REV_A_EN
    // Rev A: a natural reload from zero with latch=0 does not fire.
    assign fire_ok = (counter != 8'd0) || reload_req;
`else
    assign fire_ok = 1'b1;
`endif

    always_comb begin
        latch_nxt   = latch;
        counter_nxt = counter;
        reload_nxt  = reload_req;
        irq_en_nxt  = irq_en;
        pending_nxt = pending;

        if (wr_latch) begin
            latch_nxt = reg_data;
        end
        if (wr_ack) begin
            irq_en_nxt = 1'b0;
        end else if (wr_en) begin
            irq_en_nxt = 1'b1;
        end

        // Same-cycle writes are folded in first, so a new latch/enable/reload applies to this tick.
        if (tick_en) begin
            if ((counter == 8'd0) || reload_req) begin
                counter_nxt = latch_nxt;
                reload_nxt  = 1'b0;
            end else begin
                counter_nxt = counter - 8'd1;
            end
            if ((counter_nxt == 8'd0) && irq_en_nxt && fire_ok) begin
                pending_nxt = 1'b1;
            end
        end

        if (!enable || wr_ack) begin
            pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            latch       <= 8'd0;
            counter     <= 8'd0;
            reload_flag <= 1'b0;
            irq_en      <= 1'b0;
            pending     <= 1'b0;
        end else begin
            latch       <= latch_nxt;
            counter     <= counter_nxt;
            reload_flag <= reload_nxt;
            irq_en      <= irq_en_nxt;
            pending     <= pending_nxt;
        end
    end

    assign irq         = ~pending;
    assign counter_dbg = counter;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Bench for mmc3_scanline_irq: directed scenarios plus random register/A12 traffic
// checked against a rule-level model of the scanline counter.
module tb_mmc3_scanline_irq;

    localparam int SYNC = 2;
    localparam int MIN  = 3;

    logic       m2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       reg_we = 1'b0;
    logic [1:0] reg_sel = 2'd0;
    logic [7:0] reg_data = 8'd0;
    logic       ppu_a12 = 1'b0;
    logic       irq;
    logic [7:0] counter_dbg;

    int tests = 0;
    int fails = 0;

    // Reference state, kept as plain integers/bits.
    int m_latch = 0;
    int m_cnt = 0;
    bit m_reload = 0;
    bit m_en = 0;
    bit m_pend = 0;
    int low_run = 0;

    mmc3_scanline_irq #(.A12_LOW_MIN(MIN), .SYNC_STAGES(SYNC)) dut (
        .m2(m2), .rst_n(rst_n), .enable(enable), .reg_we(reg_we), .reg_sel(reg_sel),
        .reg_data(reg_data), .ppu_a12(ppu_a12), .irq(irq), .counter_dbg(counter_dbg)
    );

    always #5 m2 = ~m2;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        m_latch = 0; m_cnt = 0; m_reload = 0; m_en = 0; m_pend = 0; low_run = 0;
    endfunction

    // Writes are applied before the tick so same-cycle writes affect that tick.
    function automatic void model_event(bit do_tick, bit do_wr, int sel, int data);
        int prev;
        bit rl;
        if (!enable) return;
        if (do_wr) begin
            case (sel)
                0: m_latch = data;
                1: m_reload = 1;
                2: begin m_en = 0; m_pend = 0; end
                default: m_en = 1;
            endcase
        end
        if (do_tick) begin
            prev = m_cnt;
            rl = m_reload;
            if (m_cnt == 0 || m_reload) begin
                m_cnt = m_latch;
                m_reload = 0;
            end else begin
                m_cnt = m_cnt - 1;
            end
`ifdef MMC3_IRQ_REV_A_EN
            if (m_cnt == 0 && m_en && (prev != 0 || rl)) m_pend = 1;
`else
            if (m_cnt == 0 && m_en) m_pend = 1;
`endif
        end
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(string tag);
        check({tag, "_cnt"}, counter_dbg, 8'(m_cnt));
        check({tag, "_irq"}, {7'd0, irq}, {7'd0, ~m_pend});
    endtask

    task automatic step();
        @(posedge m2);
        #1;
        if (!rst_n) low_run = 0;
        else if (!ppu_a12) low_run++;
        if (rst_n && !enable) m_pend = 0;
    endtask

    task automatic write(int sel, int data);
        reg_we = 1'b1;
        reg_sel = 2'(sel);
        reg_data = 8'(data);
        step();
        reg_we = 1'b0;
        model_event(0, 1, sel, data);
        check_state("write");
    endtask

    // A12 low for `low` samples then high; the tick lands SYNC+1 edges after the rise,
    // optionally with a register write on that same edge.
    task automatic pulse(int low, bit do_wr = 0, int sel = 0, int data = 0);
        bit counted;
        ppu_a12 = 1'b0;
        repeat (low) step();
        counted = (low_run >= MIN);
        low_run = 0;
        ppu_a12 = 1'b1;
        repeat (SYNC) step();
        check_state("pre_tick");
        if (do_wr) begin
            reg_we = 1'b1;
            reg_sel = 2'(sel);
            reg_data = 8'(data);
        end
        step();
        reg_we = 1'b0;
        model_event(counted, do_wr, sel, data);
        check_state(do_wr ? "tick_wr" : "tick");
        step();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge m2);
        #1;
        check_state("reset");
        rst_n = 1'b1;

        // Basic countdown 3,2,1,0 then ack.
        write(0, 8'h03); write(1, 0); write(3, 0);
        repeat (4) pulse(8);
        check("basic_irq", {7'd0, irq}, 8'd0);
        write(2, 0);

        // Glitch filter: low time 2 ignored, low time 3 counted.
        write(0, 5); write(1, 0); write(3, 0);
        pulse(8);
        pulse(2); pulse(2);
        check("filter_hold", counter_dbg, 8'd5);
        pulse(3); pulse(3);
        check("filter_dec", counter_dbg, 8'd3);

        // Latch zero.
        write(2, 0); write(0, 0); write(1, 0); write(3, 0);
        pulse(8); write(2, 0); write(3, 0);
        pulse(8); write(2, 0); write(3, 0);
        pulse(8); write(2, 0);

        // Simultaneous events.
        write(0, 1); write(1, 0); write(3, 0);
        pulse(8);
        pulse(8, 1, 2, 0);
        check("sim_ack_cnt", counter_dbg, 8'd0);
        check("sim_ack_irq", {7'd0, irq}, 8'd1);
        write(1, 0);
        pulse(8, 1, 0, 8'h10);
        check("sim_latch", counter_dbg, 8'h10);

        // Enable gating.
        write(0, 1); write(1, 0); write(3, 0);
        pulse(8); pulse(8);
        enable = 1'b0;
        step();
        check_state("gate_off");
        pulse(8); pulse(8);
        write(0, 9);
        write(1, 0);
        enable = 1'b1;
        step();
        check_state("gate_on");

        // Random traffic.
        for (int i = 0; i < 120; i++) begin
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: write(r, $urandom_range(0, 3));
                4, 5, 6: pulse($urandom_range(1, 7));
                7: pulse($urandom_range(1, 7), 1, $urandom_range(0, 3), $urandom_range(0, 3));
                8: begin enable = ~enable; step(); check_state("rnd_en"); end
                default: write(2, 0);
            endcase
        end
        enable = 1'b1;
        step();
        check_state("rnd_end");

        // Asynchronous reset between edges.
        write(0, 8'h42); write(1, 0);
        pulse(8);
        check("pre_reset", counter_dbg, 8'h42);
        ppu_a12 = 1'b0;
        @(posedge m2);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("async_reset");
        @(posedge m2);
        #1;
        rst_n = 1'b1;
        low_run = 0;
        write(0, 2); write(1, 0); write(3, 0);
        pulse(8); pulse(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
